// File: rtl/timer.sv
// Memory-mapped machine timer: 64-bit prescaled mtime, 64-bit mtimecmp and a level interrupt.
// Single-cycle ce/req/gnt slave handshake; each access is granted one cycle after it is accepted.
module timer #(
  parameter logic [63:0] CMP_RESET   = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [7:0]  PRESC_RESET = 8'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ce_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [1:0]  hb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StAck  = 1'b1;

  localparam logic [2:0] AddrMtimeLo = 3'd0;
  localparam logic [2:0] AddrMtimeHi = 3'd1;
  localparam logic [2:0] AddrCmpLo   = 3'd2;
  localparam logic [2:0] AddrCmpHi   = 3'd3;
  localparam logic [2:0] AddrCtrl    = 3'd4;
  localparam logic [2:0] AddrStatus  = 3'd5;

  logic [0:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  hb_q, hb_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        irq_q, irq_d;

  logic        gnt;
  logic        wr_word;
  logic        rd_lo;
  logic        tick;
  logic        cmp_hit;
  logic [31:0] rd_mux;

  // Only addr_i[4:2] selects a register; the rest of the address is don't-care.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

  always_comb begin
    gnt     = (state_q == StAck);
    wr_word = gnt & we_q & (hb_q == 2'b10);
    rd_lo   = gnt & ~we_q & (addr_q == AddrMtimeLo);
    tick    = en_q & (pcnt_q == presc_q);
    cmp_hit = (mtime_q >= mtimecmp_q);
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr_q)
      AddrMtimeLo: rd_mux = mtime_q[31:0];
      AddrMtimeHi: rd_mux = hi_shadow_q;
      AddrCmpLo:   rd_mux = mtimecmp_q[31:0];
      AddrCmpHi:   rd_mux = mtimecmp_q[63:32];
      AddrCtrl:    rd_mux = {16'd0, presc_q, 6'd0, ie_q, en_q};
      AddrStatus:  rd_mux = {31'd0, cmp_hit};
      default:     rd_mux = 32'd0;
    endcase
  end

  assign gnt_o   = gnt;
  assign rdata_o = gnt ? rd_mux : 32'd0;
  assign irq_o   = irq_q;

  // Handshake: accept only in IDLE, so back-to-back requests see one access per two cycles.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    hb_d    = hb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (ce_i && req_i) begin
          state_d = StAck;
          we_d    = we_i;
          hb_d    = hb_i;
          addr_d  = addr_i[4:2];
          wdata_d = wdata_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    en_d        = en_q;
    ie_d        = ie_q;
    presc_d     = presc_q;
    pcnt_d      = pcnt_q;
    hi_shadow_d = hi_shadow_q;
    irq_d       = ie_q & cmp_hit;

    if (en_q) begin
      if (tick) begin
        pcnt_d  = 8'd0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        pcnt_d = pcnt_q + 8'd1;
      end
    end else begin
      pcnt_d = 8'd0;
    end

    // A write to one mtime half replaces the ticked value, so the increment is dropped.
    if (wr_word) begin
      case (addr_q)
        AddrMtimeLo: mtime_d = {mtime_q[63:32], wdata_q};
        AddrMtimeHi: mtime_d = {wdata_q, mtime_q[31:0]};
        AddrCmpLo:   mtimecmp_d = {mtimecmp_q[63:32], wdata_q};
        AddrCmpHi:   mtimecmp_d = {wdata_q, mtimecmp_q[31:0]};
        AddrCtrl: begin
          en_d    = wdata_q[0];
          ie_d    = wdata_q[1];
          presc_d = wdata_q[15:8];
          pcnt_d  = 8'd0;
        end
        default: ;
      endcase
    end

    if (rd_lo) begin
      hi_shadow_d = mtime_q[63:32];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      hb_q        <= 2'b00;
      addr_q      <= 3'd0;
      wdata_q     <= 32'd0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= CMP_RESET;
      hi_shadow_q <= 32'd0;
      en_q        <= 1'b0;
      ie_q        <= 1'b0;
      presc_q     <= PRESC_RESET;
      pcnt_q      <= 8'd0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      hb_q        <= hb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      hi_shadow_q <= hi_shadow_d;
      en_q        <= en_d;
      ie_q        <= ie_d;
      presc_q     <= presc_d;
      pcnt_q      <= pcnt_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios plus randomized bus traffic,
// all checked against a cycle-level behavioural model of the register file.
module tb_timer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ce_i = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic        we_i = 1'b0;
  logic [1:0]  hb_i = 2'b10;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic        irq_o;

  timer dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .ce_i    (ce_i),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .we_i    (we_i),
    .hb_i    (hb_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [63:0] m_time, m_cmp;
  logic [31:0] m_shadow;
  logic        m_en, m_ie, m_irq;
  int          m_presc, m_pc;
  logic        wr_pend, snap_pend;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_hb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_time = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 32'd0;
    m_en = 1'b0; m_ie = 1'b0; m_irq = 1'b0; m_presc = 0; m_pc = 0;
    wr_pend = 1'b0; snap_pend = 1'b0; wr_addr = 3'd0; wr_data = 32'd0; wr_hb = 2'b10;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_time[31:0];
      3'd1:    return m_shadow;
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {16'd0, m_presc[7:0], 6'd0, m_ie, m_en};
      3'd5:    return {31'd0, (m_time >= m_cmp)};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge: advance the model from its pre-edge state, then check irq.
  task automatic step();
    logic        tk, nirq;
    logic [63:0] nt;
    int          npc;
    @(posedge clk_i);
    tk   = m_en && (m_pc == m_presc);
    nirq = m_ie && (m_time >= m_cmp);
    nt   = tk ? m_time + 64'd1 : m_time;
    npc  = (!m_en || tk) ? 0 : m_pc + 1;
    if (snap_pend) m_shadow = m_time[63:32];
    if (wr_pend && wr_hb == 2'b10) begin
      case (wr_addr)
        3'd0: nt = {m_time[63:32], wr_data};
        3'd1: nt = {wr_data, m_time[31:0]};
        3'd2: m_cmp = {m_cmp[63:32], wr_data};
        3'd3: m_cmp = {wr_data, m_cmp[31:0]};
        3'd4: begin
          m_en = wr_data[0]; m_ie = wr_data[1]; m_presc = int'(wr_data[15:8]); npc = 0;
        end
        default: ;
      endcase
    end
    m_time = nt; m_pc = npc; m_irq = nirq;
    wr_pend = 1'b0; snap_pend = 1'b0;
    #1;
    chk("irq", {63'd0, irq_o}, {63'd0, m_irq});
  endtask

  task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                      input logic [1:0] hb, output logic [31:0] rd);
    logic [31:0] ra;
    ra = $urandom;
    ra[4:2] = a;
    ce_i = 1'b1; req_i = 1'b1; we_i = w; addr_i = ra; wdata_i = d; hb_i = hb;
    step();
    ce_i = 1'b0; req_i = 1'b0; we_i = 1'b0; wdata_i = $urandom; hb_i = 2'($urandom % 3);
    chk("gnt_ack", {63'd0, gnt_o}, 64'd1);
    rd = rdata_o;
    if (!w) chk($sformatf("rd[%0d]", a), {32'd0, rdata_o}, {32'd0, model_read(a)});
    wr_pend = w; wr_addr = a; wr_data = d; wr_hb = hb;
    snap_pend = !w && (a == 3'd0);
    step();
    chk("gnt_idle", {63'd0, gnt_o}, 64'd0);
    chk("rdata_idle", {32'd0, rdata_o}, 64'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] rd;
    xfer(1'b1, a, d, 2'b10, rd);
  endtask

  task automatic rd_chk(input logic [2:0] a);
    logic [31:0] rd;
    xfer(1'b0, a, $urandom, 2'($urandom % 3), rd);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 63));
      1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      2:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset values on every address
    for (int a = 0; a < 8; a++) rd_chk(3'(a));

    // Counting with presc = 3, then hold with en = 0
    wr(3'd4, 32'h0000_0301);
    repeat (40) step();
    rd_chk(3'd0);
    wr(3'd4, 32'h0);
    rd_chk(3'd0);
    repeat (20) step();
    rd_chk(3'd0);

    // Interrupt at mtime = 20, cleared by raising mtimecmp
    wr(3'd0, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd20);
    wr(3'd4, 32'h0000_0003);
    repeat (30) step();
    rd_chk(3'd5);
    wr(3'd2, 32'd1000);
    repeat (3) step();
    rd_chk(3'd5);

    // Carry into the high half, then 64-bit wrap with ie = 0
    wr(3'd4, 32'h0000_0001);
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd1, 32'h0);
    repeat (4) step();
    rd_chk(3'd0);
    rd_chk(3'd1);
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd0, 32'hFFFF_FFFF);
    repeat (3) step();
    rd_chk(3'd0);
    rd_chk(3'd1);

    // Stale shadow, ignored byte/half writes
    wr(3'd1, 32'h0000_00AA);
    rd_chk(3'd1);
    xfer(1'b1, 3'd2, 32'h1234_5678, 2'b00, rd);
    xfer(1'b1, 3'd2, 32'h1234_5678, 2'b01, rd);
    rd_chk(3'd2);

    // Continuous request: grant on alternate cycles only
    ce_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_001C;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("gnt_stream", {63'd0, gnt_o}, {63'd0, ((i % 2) == 0)});
    end
    ce_i = 1'b0; req_i = 1'b0;

    // Write to MTIME_LO on a tick cycle with presc = 0
    wr(3'd4, 32'h0000_0001);
    wr(3'd0, 32'd5);
    rd_chk(3'd0);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    wr(3'($urandom_range(0, 3)), rand_val());
        2:       wr(3'd4, {16'd0, 8'($urandom_range(0, 3)), 6'd0, 1'($urandom), 1'($urandom_range(0, 3) != 0)});
        3:       wr(3'($urandom_range(5, 7)), $urandom);
        4, 5:    rd_chk(3'($urandom_range(0, 7)));
        6:       repeat ($urandom_range(0, 6)) step();
        7, 8:    begin rd_chk(3'd0); rd_chk(3'd1); end
        default: xfer(1'b1, 3'($urandom_range(0, 4)), $urandom, 2'($urandom_range(0, 1)), rd);
      endcase
    end

    // Reset during an ACK cycle: grant drops at once and the write is lost
    ce_i = 1'b1; req_i = 1'b1; we_i = 1'b1; hb_i = 2'b10; addr_i = 32'h0; wdata_i = 32'h1234;
    step();
    chk("gnt_pre_rst", {63'd0, gnt_o}, 64'd1);
    rst_ni = 1'b0;
    ce_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
    #1;
    chk("gnt_in_rst", {63'd0, gnt_o}, 64'd0);
    chk("rdata_in_rst", {32'd0, rdata_o}, 64'd0);
    chk("irq_in_rst", {63'd0, irq_o}, 64'd0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int a = 0; a < 8; a++) rd_chk(3'(a));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer.md
Name: timer

Overview:
- Memory-mapped machine timer peripheral on the system bus, selected by BUS_CE[3]; a sibling of the UROM, SRAM and UART slaves.
- Holds a 64-bit free-running counter (mtime), advanced through an 8-bit prescaler, and a 64-bit compare register (mtimecmp).
- Drives a level interrupt into the core's i_MEI_1 input.
- Follows the same ce/req/gnt slave handshake as the other bus peripherals.

Parameters:
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.
- PRESC_RESET, 8'd0, reset value of CTRL.presc.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- ce_i  input  1  chip enable (BUS_CE[3]).
- req_i  input  1  bus request.
- gnt_o  output  1  grant; one-cycle pulse that completes an access.
- we_i  input  1  1 = write, 0 = read.
- hb_i  input  2  access size: 2'b10 word, 2'b01 half, 2'b00 byte.
- addr_i  input  32  byte address; only addr_i[4:2] is decoded.
- wdata_i  input  32  write data.
- rdata_o  output  32  read data, valid while gnt_o = 1.
- irq_o  output  1  timer interrupt, to i_MEI_1.

Behaviour:
- Interface decision: one clock (clk_i). Reset rst_ni is asynchronous and active-low. All state is clocked on the rising edge of clk_i.
- Reset values:
  - mtime = 0; mtimecmp = CMP_RESET; hi_shadow = 0.
  - CTRL: en = 0, ie = 0, presc = PRESC_RESET; prescale counter = 0.
  - gnt_o = 0, rdata_o = 0, irq_o = 0.
- Register map (addr_i[4:2]):
  - 0 MTIME_LO: read/write.
  - 1 MTIME_HI: read/write.
  - 2 MTIMECMP_LO: read/write.
  - 3 MTIMECMP_HI: read/write.
  - 4 CTRL: bit0 en, bit1 ie, bits[15:8] presc; other bits read 0.
  - 5 STATUS: read-only; bit0 = (mtime >= mtimecmp).
  - 6, 7: read 0; writes ignored.
- Handshake FSM, two states:
  - IDLE: on ce_i & req_i, latch we/addr/wdata/hb and go to ACK.
  - ACK: gnt_o = 1 for exactly one cycle, rdata_o holds the read result, then return to IDLE.
  - A request present during ACK is not accepted; it is accepted in the following IDLE cycle. Maximum throughput is one access per 2 cycles.
  - rdata_o returns to 0 when gnt_o = 0.
  - Write data commits at the clock edge that ends the ACK cycle.
- Write rules:
  - Only hb = word writes modify registers; half and byte writes are granted but ignored.
  - Reads return the full 32-bit word regardless of hb.
- Coherent 64-bit read:
  - A read of MTIME_LO returns mtime[31:0] and snapshots mtime[63:32] into hi_shadow in the same cycle.
  - A read of MTIME_HI returns hi_shadow, not live mtime. Software reads LO then HI.
- Prescaler and counting:
  - When en = 1, the prescale counter increments each cycle.
  - When the prescale counter equals presc, a tick fires and the counter returns to 0.
  - On a tick, mtime <= mtime + 1 as a full 64-bit add; it wraps from 2^64-1 to 0.
  - presc = 0 gives one tick per cycle.
  - When en = 0, the prescale counter holds at 0 and mtime holds.
  - A write to CTRL clears the prescale counter.
- Simultaneous events:
  - A write to MTIME_LO or MTIME_HI in a tick cycle takes the written value for that half. The other half keeps its pre-tick value, and the increment is dropped.
  - A write to mtimecmp takes effect on the compare from the next cycle.
- Interrupt:
  - irq_o is registered: irq_o <= ie & (mtime >= mtimecmp), using an unsigned 64-bit compare.
  - irq_o is a level, and clears only when mtimecmp is raised, mtime is lowered, or ie is cleared.
  - Latency: irq_o rises 1 cycle after the compare first holds.
- Reset asserted mid-access: gnt_o drops asynchronously, no write commits, and the FSM returns to IDLE.

Test Plan:
1. Reset: release rst_ni, then read all 8 addresses. Required: gnt_o pulses one cycle after each req; data reads 0, 0, FFFFFFFF, FFFFFFFF, 0, 0, 0, 0; irq_o = 0.
2. Count with presc = 3: write CTRL = 0x0301, wait 40 cycles, read MTIME_LO. Required: value 10 (±1 for the access cycles). Then write CTRL = 0 and confirm mtime holds across 20 cycles.
3. Interrupt: write MTIMECMP_HI = 0, MTIMECMP_LO = 20, CTRL = 0x0003. Required: irq_o rises exactly 1 cycle after mtime reaches 20. Writing MTIMECMP_LO = 1000 drops irq_o within 2 cycles.
4. Carry and wrap with en, presc = 0:
   - Write MTIME_LO = FFFFFFFE, MTIME_HI = 0. Read LO then HI after the carry: required HI = 1.
   - Write HI = FFFFFFFF, LO = FFFFFFFF: required mtime wraps to 0 with no irq_o glitch while mtimecmp = CMP_RESET.
5. Shadow and handshake:
   - Read HI before LO: required returns the stale hi_shadow.
   - Byte write to CMP_LO: required gnt_o is given and the register is unchanged.
   - Hold ce/req continuously: required gnt_o on alternate cycles only.
6. Collision and reset:
   - Write MTIME_LO = 5 on a tick cycle with presc = 0: required mtime_lo = 5 next cycle, no increment.
   - Assert rst_ni during an ACK: required gnt_o = 0 immediately and registers at reset values.
